ram_1clk_stream_reader: RTL and testbench

//  Read-side controller for a 1W/1R inferred RAM: one registered read port, no read enable, 1-cycle read latency.

---
 rtl/ram_1clk_stream_reader_pkg.sv | 24 ++
 rtl/ram_1clk_stream_reader_if.sv | 12 +
 rtl/ram_1clk_stream_reader_obuf.sv | 60 ++++++
 rtl/ram_1clk_stream_reader.sv | 87 ++++++++
 tb/tb_ram_1clk_stream_reader.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_1clk_stream_reader_pkg.sv
// Shared helpers for the single-clock RAM stream reader: address sizing and
// wrap-aware pointer occupancy.
package ram_1clk_stream_reader_pkg;

   // Entries held by the output buffer; the issue credit is sized to this.
   localparam int unsigned C_OBUF_DEPTH = 2;

   function automatic int unsigned clog2s(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < {32'd0, v}) r = i + 1;
      end
      return r;
   endfunction

   // Occupancy a-b for pointers that are 'bits' wide (wrap bit included).
   function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned bits);
      return (a - b) & ((32'd1 << bits) - 32'd1);
   endfunction

endpackage

// File: rtl/ram_1clk_stream_reader_if.sv
// Output stream of the RAM reader.
// Handshake: a word transfers on a CLK edge where RD_VALID && RD_READY; once
// RD_VALID is high, RD_DATA holds and RD_VALID stays high until that transfer
// (only reset or flush can withdraw it). RD_READY may depend on RD_VALID.
interface ram_1clk_stream_reader_if #(parameter int C_RAM_WIDTH = 32) ();
   logic [C_RAM_WIDTH-1:0] RD_DATA;
   logic                   RD_VALID;
   logic                   RD_READY;

   modport master (output RD_DATA, output RD_VALID, input RD_READY);
   modport slave  (input RD_DATA, input RD_VALID, output RD_READY);
endinterface

// File: rtl/ram_1clk_stream_reader_obuf.sv
// Two-entry output FIFO: entry 0 is the head and drives the stream directly
// from flops, entry 1 catches the word still in flight when the head stalls.
module ram_1clk_stream_reader_obuf #(
   parameter int C_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               push,
   input  logic [C_WIDTH-1:0] push_data,
   input  logic               pop,
   output logic [C_WIDTH-1:0] head_data,
   output logic               head_valid,
   output logic [1:0]         count
);

   logic [C_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
   logic               valid0_q, valid0_d, valid1_q, valid1_d;

   always_comb begin
      data0_d  = data0_q;
      data1_d  = data1_q;
      valid0_d = valid0_q;
      valid1_d = valid1_q;
      // Shift on pop first, then place the pushed word in the first free slot.
      if (pop) begin
         data0_d  = data1_q;
         valid0_d = valid1_q;
         valid1_d = 1'b0;
      end
      if (push) begin
         if (!valid0_d) begin
            data0_d  = push_data;
            valid0_d = 1'b1;
         end else begin
            data1_d  = push_data;
            valid1_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         data0_q  <= '0;
         data1_q  <= '0;
         valid0_q <= 1'b0;
         valid1_q <= 1'b0;
      end else begin
         data0_q  <= data0_d;
         data1_q  <= data1_d;
         valid0_q <= valid0_d;
         valid1_q <= valid1_d;
      end
   end

   assign head_data  = data0_q;
   assign head_valid = valid0_q;
   assign count      = {1'b0, valid0_q} + {1'b0, valid1_q};

endmodule

// File: rtl/ram_1clk_stream_reader.sv
// Read-side controller for a 1W/1R RAM with 1-cycle registered read: issues
// reads against a 2-word credit and returns the consumed pointer to the writer.
module ram_1clk_stream_reader
   import ram_1clk_stream_reader_pkg::*;
#(
   parameter int C_RAM_WIDTH = 32,
   parameter int C_RAM_DEPTH = 1024,
   localparam int C_ADDR_BITS = int'(clog2s(C_RAM_DEPTH))
) (
   input  logic                   CLK,
   input  logic                   RST_IN,
   input  logic [C_ADDR_BITS:0]   WR_PTR,
   output logic [C_ADDR_BITS:0]   RD_PTR,
   input  logic                   FLUSH,
   output logic [C_ADDR_BITS-1:0] ADDRB,
   input  logic [C_RAM_WIDTH-1:0] DOUTB,
   output logic                   RD_EMPTY,
   ram_1clk_stream_reader_if.master rd_if
);

   localparam int unsigned C_PTR_BITS = C_ADDR_BITS + 1;
   typedef logic [C_ADDR_BITS:0] ptr_t;

   ptr_t       issue_ptr_q, issue_ptr_d;
   ptr_t       rd_ptr_q, rd_ptr_d;
   logic       pend_q, pend_d;
   logic       pop, avail, issue;
   logic [1:0] obuf_cnt;
   logic [2:0] credit_used;

   assign pop         = rd_if.RD_VALID & rd_if.RD_READY;
   assign avail       = (issue_ptr_q != WR_PTR);
   // Words buffered plus in flight, net of this cycle's pop, must stay below
   // the buffer depth so a capture always finds a free slot.
   assign credit_used = {1'b0, obuf_cnt} + {2'b0, pend_q} - {2'b0, pop};
   assign issue       = avail && (credit_used < 3'(C_OBUF_DEPTH)) && !FLUSH;

   always_comb begin
      issue_ptr_d = issue_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      pend_d      = issue;
      if (issue) issue_ptr_d = issue_ptr_q + ptr_t'(1);
      if (pop)   rd_ptr_d    = rd_ptr_q + ptr_t'(1);
      if (FLUSH) begin
         issue_ptr_d = WR_PTR;
         rd_ptr_d    = WR_PTR;
         pend_d      = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST_IN) begin
         issue_ptr_q <= '0;
         rd_ptr_q    <= '0;
         pend_q      <= 1'b0;
      end else begin
         issue_ptr_q <= issue_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         pend_q      <= pend_d;
      end
   end

   ram_1clk_stream_reader_obuf #(.C_WIDTH(C_RAM_WIDTH)) u_obuf (
      .clk        (CLK),
      .rst        (RST_IN),
      .clear      (FLUSH),
      .push       (pend_q),
      .push_data  (DOUTB),
      .pop        (pop),
      .head_data  (rd_if.RD_DATA),
      .head_valid (rd_if.RD_VALID),
      .count      (obuf_cnt)
   );

   assign ADDRB    = issue_ptr_q[C_ADDR_BITS-1:0];
   assign RD_PTR   = rd_ptr_q;
   assign RD_EMPTY = (ptr_diff(32'(WR_PTR), 32'(rd_ptr_q), C_PTR_BITS) == 32'd0);

   a_credit : assert property (@(posedge CLK) disable iff (RST_IN)
      ({1'b0, obuf_cnt} + {2'b0, pend_q}) <= 3'(C_OBUF_DEPTH));
   a_no_overflow : assert property (@(posedge CLK) disable iff (RST_IN)
      !(pend_q && pop && (obuf_cnt == 2'(C_OBUF_DEPTH))));
   // A writer stepping backwards or past a full RAM shows up as occupancy > depth.
   a_wr_ptr_sane : assert property (@(posedge CLK) disable iff (RST_IN)
      ptr_diff(32'(WR_PTR), 32'(rd_ptr_q), C_PTR_BITS) <= 32'(C_RAM_DEPTH));

endmodule

// File: tb/tb_ram_1clk_stream_reader.sv
// Bench: behavioural RAM plus a pointer-driven writer feed the reader; a
// negedge monitor checks every presented word against the written-word queue.
module tb_ram_1clk_stream_reader;
  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int AB    = 4;
  localparam int PB    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [PB-1:0] wr_ptr;
  logic [PB-1:0] rd_ptr;
  logic          flush;
  logic [AB-1:0] addrb;
  logic [W-1:0]  doutb;
  logic          rd_empty;

  ram_1clk_stream_reader_if #(.C_RAM_WIDTH(W)) rd_if ();

  ram_1clk_stream_reader #(.C_RAM_WIDTH(W), .C_RAM_DEPTH(DEPTH)) dut (
    .CLK      (clk),
    .RST_IN   (rst),
    .WR_PTR   (wr_ptr),
    .RD_PTR   (rd_ptr),
    .FLUSH    (flush),
    .ADDRB    (addrb),
    .DOUTB    (doutb),
    .RD_EMPTY (rd_empty),
    .rd_if    (rd_if)
  );

  // ---- clock / RAM model ----
  always #5 clk = ~clk;

  logic [W-1:0] mem [DEPTH];
  always @(posedge clk) doutb <= mem[addrb];

  // ---- scoreboard state ----
  logic [W-1:0]  exp_q[$];
  logic [PB-1:0] exp_rd_ptr;
  int            tests = 0;
  int            fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---- driver tasks ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic writer_full();
    logic [PB-1:0] occ;
    occ = wr_ptr - rd_ptr;
    return occ == 5'(DEPTH);
  endfunction

  task automatic write_word(input logic [W-1:0] d);
    mem[wr_ptr[AB-1:0]] = d;
    exp_q.push_back(d);
    wr_ptr = wr_ptr + 5'd1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    flush = 1'b0;
    rd_if.RD_READY = 1'b0;
    wr_ptr = '0;
    exp_q.delete();
    exp_rd_ptr = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(rd_if.RD_VALID), 32'd0);
    check({tag, "_data"},  rd_if.RD_DATA, 32'd0);
    check({tag, "_addrb"}, 32'(addrb), 32'd0);
    check({tag, "_rd_ptr"}, 32'(rd_ptr), 32'd0);
    check({tag, "_empty"}, 32'(rd_empty), 32'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    rd_if.RD_READY = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d words left expected 0", tag, exp_q.size());
    end
  endtask

  // ---- monitor: compare every presented word with the model queue ----
  always @(negedge clk) begin
    logic [2:0] cu;
    if (!rst) begin
      if (rd_if.RD_VALID) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h expected no valid word", rd_if.RD_DATA);
        end else begin
          check("rd_data", rd_if.RD_DATA, exp_q[0]);
          if (rd_if.RD_READY) begin
            check("rd_ptr_at_pop", 32'(rd_ptr), 32'(exp_rd_ptr));
            void'(exp_q.pop_front());
            exp_rd_ptr = exp_rd_ptr + 5'd1;
          end
        end
      end
      cu = {1'b0, dut.obuf_cnt} + {2'b0, dut.pend_q};
      check("credit_le_2", 32'(cu <= 3'd2), 32'd1);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---- stimulus ----
  initial begin
    int written;
    int n;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    do_reset();
    check_reset_outputs("reset");

    // 1: four words, ready high; first valid two cycles after WR_PTR=1.
    for (int i = 0; i < 6; i++) begin
      rd_if.RD_READY = 1'b1;
      if (i < 4) write_word(32'hA0 + 32'(i));
      @(negedge clk);
      check("t1_valid_cycle", 32'(rd_if.RD_VALID), 32'(i >= 2));
      step();
    end
    repeat (3) step();
    check("t1_rd_ptr", 32'(rd_ptr), 32'd4);
    check("t1_empty", 32'(rd_empty), 32'd1);

    // 2: eight words under random backpressure.
    written = 0;
    n = 0;
    while ((written < 8 || exp_q.size() != 0) && n < 300) begin
      rd_if.RD_READY = 1'($urandom_range(0, 1));
      if (written < 8 && $urandom_range(0, 3) != 0 && !writer_full()) begin
        write_word($urandom());
        written++;
      end
      step();
      n++;
    end
    check("t2_done", 32'(written == 8 && exp_q.size() == 0), 32'd1);
    step();
    check("t2_rd_ptr", 32'(rd_ptr), 32'd12);

    // 3: forty words continuous, writer gated on full, across two wraps.
    do_reset();
    written = 0;
    n = 0;
    rd_if.RD_READY = 1'b1;
    while ((written < 40 || exp_q.size() != 0) && n < 400) begin
      if (written < 40 && !writer_full()) begin
        write_word(32'h3000 + 32'(written));
        written++;
      end
      step();
      n++;
    end
    check("t3_done", 32'(written == 40 && exp_q.size() == 0), 32'd1);
    step();
    check("t3_rd_ptr", 32'(rd_ptr), 32'd8);

    // 4: fill the RAM with the reader stalled, then drain.
    rd_if.RD_READY = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (!writer_full()) write_word(32'h4000 + 32'($urandom_range(0, 255)));
      step();
    end
    check("t4_occupancy", 32'(wr_ptr - rd_ptr), 32'd16);
    check("t4_writer_full", 32'(writer_full()), 32'd1);
    check("t4_not_empty", 32'(rd_empty), 32'd0);
    drain("t4", 100);
    repeat (2) step();
    check("t4_empty", 32'(rd_empty), 32'd1);
    check("t4_rd_ptr", 32'(rd_ptr), 32'd24);

    // 5: flush with unread words while valid; a pop in the flush cycle is honoured.
    rd_if.RD_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      write_word(32'h5000 + 32'(i));
      step();
    end
    n = 0;
    while (!rd_if.RD_VALID && n < 10) begin
      step();
      n++;
    end
    check("t5_valid_before_flush", 32'(rd_if.RD_VALID), 32'd1);
    rd_if.RD_READY = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    rd_if.RD_READY = 1'b0;
    exp_q.delete();
    exp_rd_ptr = wr_ptr;
    @(negedge clk);
    check("t5_valid_after_flush", 32'(rd_if.RD_VALID), 32'd0);
    check("t5_rd_ptr_eq_wr", 32'(rd_ptr), 32'(wr_ptr));
    check("t5_empty", 32'(rd_empty), 32'd1);
    step();
    write_word(32'h55);
    drain("t5", 10);
    step();
    check("t5_rd_ptr_final", 32'(rd_ptr), 32'd30);

    // 6: reset mid-stream while a read is in flight.
    rd_if.RD_READY = 1'b1;
    n = 0;
    written = 0;
    while (!(written >= 3 && dut.pend_q) && n < 20) begin
      write_word(32'h6000 + 32'(written));
      written++;
      step();
      n++;
    end
    check("t6_found_inflight", 32'(dut.pend_q), 32'd1);
    rst = 1'b1;
    rd_if.RD_READY = 1'b0;
    wr_ptr = '0;
    exp_q.delete();
    exp_rd_ptr = '0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("t6");
    rd_if.RD_READY = 1'b1;
    repeat (10) step();
    write_word(32'h66);
    drain("t6", 10);
    step();
    check("t6_rd_ptr", 32'(rd_ptr), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
